// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, flag indices and format helpers for fp_addsub_iter
package fp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } state_t;

   localparam int FLAG_W         = 4;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   function automatic int unsigned fp_bias(input int unsigned exp_w);
      return (32'd1 << (exp_w - 1)) - 32'd1;
   endfunction

   // Canonical quiet NaN in the low 1+exp_w+man_w bits: sign 0, exp all-ones, fraction MSB only.
   function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

endpackage

// File: rtl/fp_addsub_iter_if.sv
// rtl/fp_addsub_iter_if.sv - load/result handshake bundle between controller and fp_addsub_iter
interface fp_addsub_iter_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic                      load;
   logic                      op_sub;
   logic [W-1:0]              number1;
   logic [W-1:0]              number2;
   logic                      result_ack;
   logic [W-1:0]              result;
   logic                      result_ready;
   logic                      busy;
   logic [fp_pkg::FLAG_W-1:0] flags;

   modport master (
      output load, op_sub, number1, number2, result_ack,
      input  result, result_ready, busy, flags
   );

   modport slave (
      input  load, op_sub, number1, number2, result_ack,
      output result, result_ready, busy, flags
   );
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; an all-zero input returns IN_W
module fp_lzc #(
   parameter int IN_W  = 27,
   parameter int OUT_W = $clog2(IN_W + 1)
) (
   input  logic [IN_W-1:0]  i_data,
   output logic [OUT_W-1:0] o_count
);
   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      o_count = OUT_W'(IN_W);
      for (int i = 0; i < IN_W; i++) begin
         if (i_data[i]) o_count = OUT_W'(IN_W - 1 - i);
      end
   end
endmodule

// File: rtl/fp_addsub_iter.sv
// rtl/fp_addsub_iter.sv - iterative IEEE-754 add/subtract, RNE, subnormals, five-cycle FSM
// Optional: define FP_ADDSUB_FLAGS_EN to drive flags {invalid, overflow, underflow, inexact}.
module fp_addsub_iter
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic             clk,
   input logic             reset,
   fp_addsub_iter_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 4;
   localparam int LZW = $clog2(SW + 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [63:0]      QNAN64   = fp_qnan(EXP_W, MAN_W);

   state_t r_state, w_next;
   logic   w_capture;

   logic [W-1:0]   r_a, r_b, r_spec_val, r_result;
   logic           r_special, r_sign, r_eff_sub, r_ready;
   logic [EXP_W:0] r_exp;
   logic [SW-1:0]  r_ma, r_mb, r_m;
   logic [SW:0]    r_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      case (r_state)
         IDLE:  if (bus.load) begin w_next = ALIGN; w_capture = 1'b1; end
         ALIGN: w_next = ADD;
         ADD:   w_next = NORM;
         NORM:  w_next = ROUND;
         ROUND: w_next = DONE;
         DONE: begin
            if (bus.result_ack) begin
               if (bus.load) begin w_next = ALIGN; w_capture = 1'b1; end
               else          w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // ALIGN: order by magnitude (raw exp/frac bits compare as magnitude), then shift the smaller.
   logic [W-1:0]     w_big, w_sml;
   logic [EXP_W-1:0] w_e_big, w_e_sml, w_diff, w_shamt;
   logic [SW-1:0]    w_sig_big, w_sig_sml, w_shifted, w_mb;
   logic             w_a_ge, w_sat, w_sticky;

   assign w_a_ge    = r_a[W-2:0] >= r_b[W-2:0];
   assign w_big     = w_a_ge ? r_a : r_b;
   assign w_sml     = w_a_ge ? r_b : r_a;
   assign w_e_big   = (w_big[W-2:MAN_W] == '0) ? EXP_W'(1) : w_big[W-2:MAN_W];
   assign w_e_sml   = (w_sml[W-2:MAN_W] == '0) ? EXP_W'(1) : w_sml[W-2:MAN_W];
   assign w_diff    = w_e_big - w_e_sml;
   assign w_sig_big = {|w_big[W-2:MAN_W], w_big[MAN_W-1:0], 3'b000};
   assign w_sig_sml = {|w_sml[W-2:MAN_W], w_sml[MAN_W-1:0], 3'b000};
   assign w_sat     = 32'(w_diff) > 32'(MAN_W + 3);
   assign w_shamt   = w_sat ? EXP_W'(MAN_W + 3) : w_diff;
   assign w_shifted = w_sig_sml >> w_shamt;
   assign w_sticky  = |(w_sig_sml & ~({SW{1'b1}} << w_shamt));
   assign w_mb      = {w_shifted[SW-1:1], w_shifted[0] | w_sticky};

   logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_special;
   logic [W-1:0] w_spec_val;

   assign w_a_nan  = (r_a[W-2:MAN_W] == EXP_ONES) && (r_a[MAN_W-1:0] != '0);
   assign w_b_nan  = (r_b[W-2:MAN_W] == EXP_ONES) && (r_b[MAN_W-1:0] != '0);
   assign w_a_inf  = (r_a[W-2:MAN_W] == EXP_ONES) && (r_a[MAN_W-1:0] == '0);
   assign w_b_inf  = (r_b[W-2:MAN_W] == EXP_ONES) && (r_b[MAN_W-1:0] == '0);
   assign w_a_zero = r_a[W-2:0] == '0;
   assign w_b_zero = r_b[W-2:0] == '0;

   // Only the both-zero case needs a bypass; a single zero operand flows through exactly.
   always_comb begin
      w_special  = 1'b1;
      w_spec_val = r_a;
      if (w_a_nan || w_b_nan)      w_spec_val = QNAN64[W-1:0];
      else if (w_a_inf && w_b_inf) w_spec_val = (r_a[W-1] ^ r_b[W-1]) ? QNAN64[W-1:0] : r_a;
      else if (w_a_inf)            w_spec_val = r_a;
      else if (w_b_inf)            w_spec_val = r_b;
      else if (w_a_zero && w_b_zero) w_spec_val = {r_a[W-1] & r_b[W-1], {(W-1){1'b0}}};
      else                         w_special  = 1'b0;
   end

   // NORM: left shift capped so the exponent never drops below 1 (subnormal result).
   logic [LZW-1:0] w_lzc;
   logic [31:0]    w_lim, w_shl;
   logic [SW-1:0]  w_norm;

   fp_lzc #(.IN_W(SW), .OUT_W(LZW)) u_lzc (.i_data(r_sum[SW-1:0]), .o_count(w_lzc));

   assign w_lim  = 32'(r_exp) - 32'd1;
   assign w_shl  = (32'(w_lzc) < w_lim) ? 32'(w_lzc) : w_lim;
   assign w_norm = r_sum[SW-1:0] << w_shl;

   logic             w_inc, w_hid_r, w_ovf;
   logic [MAN_W+1:0] w_rnd;
   logic [EXP_W:0]   w_exp_r;
   logic [MAN_W-1:0] w_frac_r;
   logic [W-1:0]     w_packed;

   assign w_inc    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
   assign w_rnd    = {1'b0, r_m[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
   assign w_exp_r  = r_exp + {{EXP_W{1'b0}}, w_rnd[MAN_W+1]};
   assign w_frac_r = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
   assign w_hid_r  = w_rnd[MAN_W+1] | w_rnd[MAN_W];
   assign w_ovf    = w_exp_r >= {1'b0, EXP_ONES};
   assign w_packed = w_ovf ? {r_sign, EXP_ONES, {MAN_W{1'b0}}} :
                     (r_m == '0) ? {W{1'b0}} :
                     {r_sign, (w_hid_r ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac_r};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a <= '0; r_b <= '0; r_spec_val <= '0; r_result <= '0;
         r_special <= 1'b0; r_sign <= 1'b0; r_eff_sub <= 1'b0; r_ready <= 1'b0;
         r_exp <= '0; r_ma <= '0; r_mb <= '0; r_m <= '0; r_sum <= '0;
      end else begin
         if (w_capture) begin
            r_a <= bus.number1;
            r_b <= {bus.number2[W-1] ^ bus.op_sub, bus.number2[W-2:0]};
         end
         if (r_state == DONE && bus.result_ack) r_ready <= 1'b0;
         case (r_state)
            ALIGN: begin
               r_special  <= w_special;
               r_spec_val <= w_spec_val;
               r_sign     <= w_big[W-1];
               r_eff_sub  <= r_a[W-1] ^ r_b[W-1];
               r_exp      <= {1'b0, w_e_big};
               r_ma       <= w_sig_big;
               r_mb       <= w_mb;
            end
            ADD: r_sum <= r_eff_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
            NORM: begin
               if (r_sum[SW]) begin
                  r_m   <= {r_sum[SW:2], r_sum[1] | r_sum[0]};
                  r_exp <= r_exp + (EXP_W+1)'(1);
               end else begin
                  r_m   <= w_norm;
                  r_exp <= r_exp - (EXP_W+1)'(w_shl);
               end
            end
            ROUND: begin
               r_result <= r_special ? r_spec_val : w_packed;
               r_ready  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef FP_ADDSUB_FLAGS_EN
   logic              w_a_snan, w_b_snan, w_spec_inv, r_spec_inv;
   logic [FLAG_W-1:0] w_flags, r_flags;

   assign w_a_snan   = w_a_nan & ~r_a[MAN_W-1];
   assign w_b_snan   = w_b_nan & ~r_b[MAN_W-1];
   assign w_spec_inv = w_a_snan | w_b_snan | (w_a_inf & w_b_inf & (r_a[W-1] ^ r_b[W-1]));

   always_comb begin
      w_flags                 = '0;
      w_flags[FLAG_OVERFLOW]  = w_ovf;
      w_flags[FLAG_INEXACT]   = r_m[2] | r_m[1] | r_m[0] | w_ovf;
      w_flags[FLAG_UNDERFLOW] = ~r_m[SW-1] & (r_m[2] | r_m[1] | r_m[0]);
      if (r_special) begin
         w_flags               = '0;
         w_flags[FLAG_INVALID] = r_spec_inv;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_spec_inv <= 1'b0;
         r_flags    <= '0;
      end else begin
         if (r_state == ALIGN) r_spec_inv <= w_spec_inv;
         if (r_state == ROUND) r_flags    <= w_flags;
      end
   end

   assign bus.flags = r_flags;
`else
   assign bus.flags = 4'b0000;
`endif

   assign bus.result       = r_result;
   assign bus.result_ready = r_ready;
   assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_fp_addsub_iter.sv
// tb/tb_fp_addsub_iter.sv - directed vectors for single and half precision plus handshake cases
module tb_fp_addsub_iter;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

`ifdef FP_ADDSUB_FLAGS_EN
   localparam logic [3:0] FMASK = 4'hF;
`else
   localparam logic [3:0] FMASK = 4'h0;
`endif

   fp_addsub_iter_if #(.EXP_W(8), .MAN_W(23)) b32 ();
   fp_addsub_iter_if #(.EXP_W(5), .MAN_W(10)) b16 ();

   fp_addsub_iter #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .reset(reset), .bus(b32));
   fp_addsub_iter #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .reset(reset), .bus(b16));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] er, input logic [3:0] ef);
      @(negedge clk);
      b32.number1 = a; b32.number2 = b; b32.op_sub = sub; b32.load = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk({tag, ".early"}, 32'(b32.result_ready), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".rdy"}, 32'(b32.result_ready), 32'd1);
      chk({tag, ".res"}, b32.result, er);
      chk({tag, ".flg"}, 32'(b32.flags), 32'(ef & FMASK));
      @(negedge clk) b32.result_ack = 1'b1;
      @(posedge clk); #1 b32.result_ack = 1'b0;
      chk({tag, ".ack"}, 32'(b32.result_ready), 32'd0);
   endtask

   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef);
      @(negedge clk);
      b16.number1 = a; b16.number2 = b; b16.op_sub = 1'b0; b16.load = 1'b1;
      @(posedge clk); #1 b16.load = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, ".rdy"}, 32'(b16.result_ready), 32'd1);
      chk({tag, ".res"}, 32'(b16.result), 32'(er));
      chk({tag, ".flg"}, 32'(b16.flags), 32'(ef & FMASK));
      @(negedge clk) b16.result_ack = 1'b1;
      @(posedge clk); #1 b16.result_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      b32.load = 1'b0; b32.op_sub = 1'b0; b32.number1 = '0; b32.number2 = '0; b32.result_ack = 1'b0;
      b16.load = 1'b0; b16.op_sub = 1'b0; b16.number1 = '0; b16.number2 = '0; b16.result_ack = 1'b0;
      #12;
      chk("rst.res",  b32.result, 32'd0);
      chk("rst.rdy",  32'(b32.result_ready), 32'd0);
      chk("rst.busy", 32'(b32.busy), 32'd0);
      chk("rst.flg",  32'(b32.flags), 32'd0);
      @(negedge clk) reset = 1'b1;

      op32("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
      op32("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
      op32("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
      op32("above_tie", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1);
      op32("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
      op32("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
      op32("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
      op32("nz_sub_nz", 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'h0);
      op32("sub_sub",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0);
      op32("min_norm",  32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'h0);
      op32("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
      op32("zero_m1",   32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'h0);
      op32("snan",      32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
      op32("inf_fin",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0);

      op16("hp_1_1",    16'h3C00, 16'h3C00, 16'h4000, 4'h0);
      op16("hp_ovf",    16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5);

      // result must stay put while the consumer withholds ack
      @(negedge clk);
      b32.number1 = 32'h3F800000; b32.number2 = 32'h40000000; b32.op_sub = 1'b0; b32.load = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("hold.rdy", 32'(b32.result_ready), 32'd1);
         chk("hold.res", b32.result, 32'h40400000);
         @(posedge clk); #1;
      end

      // ack and load in the same cycle go straight back to ALIGN
      @(negedge clk);
      b32.number1 = 32'h3F800000; b32.number2 = 32'h3F800000; b32.load = 1'b1; b32.result_ack = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0; b32.result_ack = 1'b0;
      chk("b2b.drop", 32'(b32.result_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("b2b.busy", 32'(b32.busy), 32'd1);
         @(posedge clk); #1;
      end
      chk("b2b.early", 32'(b32.result_ready), 32'd0);
      @(posedge clk); #1;
      chk("b2b.rdy", 32'(b32.result_ready), 32'd1);
      chk("b2b.res", b32.result, 32'h40000000);
      @(negedge clk) b32.result_ack = 1'b1;
      @(posedge clk); #1 b32.result_ack = 1'b0;

      // load pulse while in ADD is ignored
      @(negedge clk);
      b32.number1 = 32'h3F800000; b32.number2 = 32'h40000000; b32.load = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0;
      @(posedge clk); #1;
      b32.number1 = 32'h40000000; b32.number2 = 32'h40000000; b32.load = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0;
      @(posedge clk); #1 chk("ign.early", 32'(b32.result_ready), 32'd0);
      @(posedge clk); #1;
      chk("ign.rdy", 32'(b32.result_ready), 32'd1);
      chk("ign.res", b32.result, 32'h40400000);
      @(negedge clk) b32.result_ack = 1'b1;
      @(posedge clk); #1 b32.result_ack = 1'b0;
      chk("ign.idle", 32'(b32.busy), 32'd0);

      // reset while in NORM aborts and clears the result
      @(negedge clk);
      b32.number1 = 32'h3F800000; b32.number2 = 32'h33800001; b32.load = 1'b1;
      @(posedge clk); #1 b32.load = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("arst.rdy",  32'(b32.result_ready), 32'd0);
      chk("arst.res",  b32.result, 32'd0);
      chk("arst.busy", 32'(b32.busy), 32'd0);
      @(negedge clk) reset = 1'b1;
      op32("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule

// File: doc/fp_addsub_iter.md
Name: fp_addsub_iter

Overview:
- Parametrised IEEE-754 floating-point add/subtract unit. Generalises the single-precision adder.
- Adds: configurable exponent and mantissa widths, subtract mode, full subnormal support, round-to-nearest-even, and correct handling of inf, NaN and signed zero.
- Multi-cycle FSM with a load/result_ready/result_ack handshake. Sits beside the other arithmetic blocks on the datapath controller bus.

Parameters:
- EXP_W, 8, exponent field width (min 3).
- MAN_W, 23, stored fraction width (min 2); total word W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  operands valid; accepted only when the block can accept (see Behaviour).
- op_sub  input  1  0: number1+number2, 1: number1-number2; sampled with load.
- number1  input  W  operand A.
- number2  input  W  operand B.
- result_ack  input  1  consumer has taken result.
- result  output  W  registered result, stable while result_ready=1.
- result_ready  output  1  result valid.
- busy  output  1  high in any state other than IDLE.
- flags  output  4  {invalid, overflow, underflow, inexact}, registered with result.

Behaviour:
- Reset (async, active-low): state=IDLE; result=0; result_ready=0; flags=0; all internal operand registers cleared.
- Reset asserted mid-operation aborts the operation. No result is produced.
- FSM states and transitions, one cycle each: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
- IDLE: when load=1, capture number1, number2 and op_sub (op_sub flips B's sign), then go to ALIGN. With load=0, stay in IDLE.
- ALIGN: unpack both operands.
  - Subnormal: effective exponent 1, hidden bit 0. Otherwise hidden bit 1.
  - Swap so A has the larger magnitude (exponent, then fraction).
  - Right-shift B's significand by the exponent difference into a significand+3 bit field (guard, round, sticky). Shifted-out bits OR into sticky.
  - Shift saturates at MAN_W+3.
- ADD: add significands if signs are equal, else subtract (A-B, never negative). Result sign = A's sign.
- NORM:
  - On carry-out: shift right 1 (sticky preserved), exponent +1.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1. The result becomes subnormal when the limit is hit.
- ROUND:
  - Round to nearest even: increment if G & (R | S | lsb).
  - Mantissa overflow from rounding bumps the exponent.
  - Exponent >= all-ones gives ±inf.
  - Pack the result; register result and flags; assert result_ready.
- DONE: hold result, flags and result_ready.
  - result_ack=1 clears result_ready at that edge.
  - If load=1 in the same cycle, the new operands are captured and the FSM goes straight to ALIGN (back-to-back). Otherwise it returns to IDLE.
  - load without result_ack in DONE is ignored. load in ALIGN..ROUND is ignored.
- Latency: result_ready rises on the 5th rising edge counting the edge that samples load. Throughput is one operation per 5 cycles with a same-cycle ack.
- Special cases (resolved in ALIGN; result still appears at normal latency):
  - Any NaN operand -> canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0).
  - inf + (-inf) after op_sub applied -> qNaN, invalid.
  - inf with a finite operand -> that inf.
  - Exact zero sum -> +0, except (-0)+(-0) -> -0.
  - A zero operand returns the other operand unchanged, with sign adjusted by op_sub.
- result_ack while result_ready=0 is ignored.

Optional Feature:
- Macro FP_ADDSUB_FLAGS_EN.
- Defined: flags is driven.
  - invalid: NaN produced by inf-inf, or a signalling NaN input.
  - overflow: rounded result is inf from finite inputs.
  - underflow: result is tiny and inexact.
  - inexact: any of G/R/S set, or overflow.
- Undefined: flags tied to 4'b0000; flag logic removed. Result is identical either way.

Decomposition:
- Package fp_pkg:
  - state enum (IDLE, ALIGN, ADD, NORM, ROUND, DONE).
  - flag bit index constants.
  - functions for bias (2^(EXP_W-1)-1) and canonical qNaN pattern, parametrised by EXP_W/MAN_W.
- Sub-module fp_lzc: parametrised leading-zero counter (input width MAN_W+4, output clog2 width), used in NORM.

Test Plan:
- Basic add, default params: load 0x3F800000 + 0x40000000, op_sub=0 -> result 0x40400000. result_ready high exactly on the 5th edge; flags 0.
- Cancellation and tie rounding:
  - op_sub=1 with 0x3F800000, 0x3F800000 -> 0x00000000.
  - 0x3F800000 + 0x33800000 -> 0x3F800000, inexact (tie to even).
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
- Specials and overflow:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow|inexact.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Subnormals:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - 0x00800000 - 0x00000001 -> 0x007FFFFF, no flags.
- Handshake:
  - Withhold result_ack 10 cycles: result and result_ready stable.
  - ack together with new load -> next result_ready 5 edges later, no IDLE cycle.
  - load pulse during ADD -> ignored.
  - reset pulse in NORM -> result_ready=0, result=0; the next load completes correctly.
- Half precision (EXP_W=5, MAN_W=10): 0x3C00 + 0x3C00 -> 0x4000; 0x7BFF + 0x7BFF -> 0x7C00.
